// File: rtl/puf_pkg.sv
// puf_pkg: shared FSM encoding and timing defaults for the PUF response path
package puf_pkg;
  localparam int PUF_CHAL_W     = 64;
  localparam int PUF_CLEAR_CYC  = 4;
  localparam int PUF_SETTLE_CYC = 16;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RACE    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_q;
  // shift the asynchronous input through two flops before anyone looks at it
  always_ff @(posedge clk)
    if (reset) {q, meta_q} <= 2'b00;
    else       {q, meta_q} <= {meta_q, d};
endmodule

// File: rtl/puf_triple_sampler.sv
// puf_triple_sampler: clears, launches and samples the arbiter PUF three times per challenge
module puf_triple_sampler
  import puf_pkg::*;
#(
  parameter int CHAL_W     = PUF_CHAL_W,
  parameter int CLEAR_CYC  = PUF_CLEAR_CYC,
  parameter int SETTLE_CYC = PUF_SETTLE_CYC,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CHAL_W-1:0] challenge,
  output logic              busy,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic              puf_clear,
  output logic              puf_launch,
  input  logic              puf_resp,
  output logic [2:0]        samples,
  output logic              samples_valid
);
  if (CLEAR_CYC < 1 || SETTLE_CYC < 3 || CLEAR_CYC > 2**CNT_W || SETTLE_CYC > 2**CNT_W) begin : g_bad_params
    $error("puf_triple_sampler: CLEAR_CYC/SETTLE_CYC out of range for CNT_W");
  end
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [2:0]          samples_q, samples_d;
  logic [CHAL_W-1:0]   chal_q, chal_d;
  logic                busy_q, busy_d, clear_q, clear_d, launch_q, launch_d, valid_q, valid_d;
  logic                resp_s;
  sync_2ff u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (puf_resp),
    .q    (resp_s)
  );
  // next-state logic; outputs are decoded from the next state so they register in step with it
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    samples_d = samples_q;
    chal_d    = chal_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_CLEAR;
        chal_d    = challenge;
        samples_d = '0;
        idx_d     = '0;
        cnt_d     = '0;
      end
      S_CLEAR: begin
        state_d = cnt_q == CNT_W'(CLEAR_CYC - 1) ? S_RACE : S_CLEAR;
        cnt_d   = cnt_q == CNT_W'(CLEAR_CYC - 1) ? '0 : cnt_q + 1'b1;
      end
      S_RACE: begin
        state_d = cnt_q == CNT_W'(SETTLE_CYC - 1) ? S_CAPTURE : S_RACE;
        cnt_d   = cnt_q == CNT_W'(SETTLE_CYC - 1) ? '0 : cnt_q + 1'b1;
      end
      S_CAPTURE: begin
        samples_d[idx_q] = resp_s;
        state_d          = idx_q == 2'd2 ? S_DONE : S_CLEAR;
        idx_d            = idx_q == 2'd2 ? idx_q : idx_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d   = state_d != S_IDLE;
    clear_d  = state_d == S_CLEAR;
    launch_d = state_d == S_RACE || state_d == S_CAPTURE;
    valid_d  = state_d == S_DONE;
  end
  // state and registered outputs; reset wins over everything, including mid-run
  always_ff @(posedge clk)
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      samples_q <= '0;
      chal_q    <= '0;
      busy_q    <= 1'b0;
      clear_q   <= 1'b0;
      launch_q  <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      samples_q <= samples_d;
      chal_q    <= chal_d;
      busy_q    <= busy_d;
      clear_q   <= clear_d;
      launch_q  <= launch_d;
      valid_q   <= valid_d;
    end
  assign busy          = busy_q;
  assign puf_challenge = chal_q;
  assign puf_clear     = clear_q;
  assign puf_launch    = launch_q;
  assign samples       = samples_q;
  assign samples_valid = valid_q;
endmodule

// File: tb/tb_puf_triple_sampler.sv
// tb_puf_triple_sampler: vector table plus random runs checked against a phase-arithmetic model
module tb_puf_triple_sampler;
  import puf_pkg::*;
  localparam int CW  = PUF_CHAL_W;
  localparam int CC  = PUF_CLEAR_CYC;
  localparam int SC  = PUF_SETTLE_CYC;
  localparam int N   = CC + SC + 1;
  localparam int LAT = 3 * N + 1;
  typedef struct {
    logic [CW-1:0] chal;
    logic [2:0]    pat;
    bit            meddle;
    int            rst_at;
  } vec_t;
  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, puf_resp = 1'b0;
  logic [CW-1:0] challenge = '0;
  logic          busy, puf_clear, puf_launch, samples_valid;
  logic [CW-1:0] puf_challenge;
  logic [2:0]    samples;
  int            n_cmp = 0, n_bad = 0;
  vec_t          vecs[5];
  always #5 clk = ~clk;
  puf_triple_sampler dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .challenge    (challenge),
    .busy         (busy),
    .puf_challenge(puf_challenge),
    .puf_clear    (puf_clear),
    .puf_launch   (puf_launch),
    .puf_resp     (puf_resp),
    .samples      (samples),
    .samples_valid(samples_valid)
  );
  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // one run: resp follows pat per sample window; model derives every output from the cycle offset
  task automatic run(input logic [CW-1:0] chal, input logic [2:0] pat, input bit meddle, input int rst_at);
    int p;
    logic e_clear, e_launch, maj;
    @(negedge clk);
    start = 1'b1;
    challenge = chal;
    @(posedge clk);
    for (int t = 1; t <= LAT; t++) begin
      if (t > 1) @(posedge clk);
      #1;
      puf_resp = t <= 3 * N ? pat[(t - 1) / N] : 1'b0;
      if (meddle && (t == 20 || t == 50 || t == LAT)) begin
        start = 1'b1;
        challenge = ~chal;
      end else start = 1'b0;
      if (t == rst_at) begin
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_mid", CW'({busy, puf_clear, puf_launch, samples_valid, samples}), '0);
        chk("reset_chal", puf_challenge, '0);
        return;
      end
      @(negedge clk);
      p        = (t - 1) % N;
      e_clear  = t <= 3 * N && p < CC;
      e_launch = t <= 3 * N && p >= CC;
      chk($sformatf("ctrl_t%0d", t), CW'({busy, puf_clear, puf_launch, samples_valid}),
          CW'({1'b1, e_clear, e_launch, t == LAT}));
      if (t == 1 || t == LAT) chk("chal", puf_challenge, chal);
      if (t == LAT) begin
        chk("samples", CW'(samples), CW'(pat));
        maj = (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
        chk("vote", CW'(maj), CW'($countones(pat) >= 2));
      end
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("idle_after", CW'({busy, samples_valid, samples}), CW'({2'b00, pat}));
  endtask
  initial begin
    int last, pulses;
    vecs[0] = '{64'hA5A5_0000_FFFF_1234, 3'b111, 1'b0, 0};
    vecs[1] = '{64'h0123_4567_89AB_CDEF, 3'b101, 1'b0, 0};
    vecs[2] = '{64'hDEAD_BEEF_0BAD_F00D, 3'b010, 1'b1, 0};
    vecs[3] = '{64'h1111_2222_3333_4444, 3'b110, 1'b0, N + CC + 5};
    vecs[4] = '{64'hFEDC_BA98_7654_3210, 3'b011, 1'b0, 0};
    repeat (3) @(negedge clk);
    chk("reset_state", CW'({busy, puf_clear, puf_launch, samples_valid, samples}), '0);
    chk("reset_chal0", puf_challenge, '0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) run(vecs[i].chal, vecs[i].pat, vecs[i].meddle, vecs[i].rst_at);
    for (int i = 0; i < 4; i++) run({$urandom, $urandom}, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);
    last   = -1;
    pulses = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 400 && pulses < 3; c++) begin
      @(negedge clk);
      if (samples_valid) begin
        if (last >= 0) chk("b2b_gap", CW'(c - last), CW'(65));
        last = c;
        pulses++;
      end
    end
    chk("b2b_pulses", CW'(pulses), CW'(3));
    start = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    chk("b2b_idle", CW'(busy), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
